// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32 core: sequences FETCH/DECODE/EXEC/MEM/WB,
// decodes the instruction class once in DECODE and drives datapath strobes from it.
module multicycle_controller (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [1:0]  ALUOp,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        instr_done,
  output logic [31:0] retired_cnt,
  output logic        trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_LW, C_SW, C_BEQ, C_ILL
  } class_e;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       trap;
  } ctrl_t;

  state_e      state_q, state_d;
  class_e      cls_q, cls_d;
  logic [31:0] cnt_q;
  ctrl_t       ctrl, ctrl_gated;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cls_d = C_ILL;
    case (opcode)
      7'b0110011: begin
        if ((funct7 == 7'b0000000 &&
             (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110)) ||
            (funct7 == 7'b0100000 && funct3 == 3'b000))
          cls_d = C_R;
      end
      7'b0000011: if (funct3 == 3'b010) cls_d = C_LW;
      7'b0100011: if (funct3 == 3'b010) cls_d = C_SW;
      7'b1100011: if (funct3 == 3'b000) cls_d = C_BEQ;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = (cls_d == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_R:        state_d = S_WB;
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ:      state_d = S_FETCH;
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEM:    if (dmem_ack) state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.imem_req = 1'b1;
        ctrl.ir_write = imem_ack;
        ctrl.pc_write = imem_ack;
      end
      S_EXEC: begin
        case (cls_q)
          C_R:        ctrl.alu_op  = 2'b10;
          C_LW, C_SW: ctrl.alu_src = 1'b1;
          C_BEQ: begin
            ctrl.alu_op     = 2'b01;
            ctrl.pc_src     = 1'b1;
            ctrl.pc_write   = zero;
            ctrl.instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address operands stay selected for the whole access.
        ctrl.dmem_req   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = (cls_q == C_LW);
        ctrl.mem_write  = (cls_q == C_SW);
        ctrl.instr_done = dmem_ack && (cls_q == C_SW);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = (cls_q == C_LW);
        ctrl.alu_op     = (cls_q == C_R) ? 2'b10 : 2'b00;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP:  ctrl.trap = 1'b1;
      default: ;
    endcase
  end

  // Reset is asynchronous, so outputs must drop the instant rstn falls.
  assign ctrl_gated = rstn ? ctrl : '0;

  assign imem_req    = ctrl_gated.imem_req;
  assign dmem_req    = ctrl_gated.dmem_req;
  assign MemRead     = ctrl_gated.mem_read;
  assign MemWrite    = ctrl_gated.mem_write;
  assign IRWrite     = ctrl_gated.ir_write;
  assign PCWrite     = ctrl_gated.pc_write;
  assign PCSrc       = ctrl_gated.pc_src;
  assign ALUOp       = ctrl_gated.alu_op;
  assign ALUSrc      = ctrl_gated.alu_src;
  assign RegWrite    = ctrl_gated.reg_write;
  assign MemtoReg    = ctrl_gated.mem_to_reg;
  assign instr_done  = ctrl_gated.instr_done;
  assign trap        = ctrl_gated.trap;
  assign retired_cnt = cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_d;
      if (ctrl.instr_done) cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule
